// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity constants and baud helper for the UART transmitter.
// Rev 1.0
`default_nettype none

package uart_pkg;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_START  = 3'd1;
   localparam logic [2:0] c_ST_DATA   = 3'd2;
   localparam logic [2:0] c_ST_PARITY = 3'd3;
   localparam logic [2:0] c_ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = c_ST_IDLE,
      ST_START  = c_ST_START,
      ST_DATA   = c_ST_DATA,
      ST_PARITY = c_ST_PARITY,
      ST_STOP   = c_ST_STOP
   } state_t;

   localparam logic c_PAR_EVEN = 1'b0;
   localparam logic c_PAR_ODD  = 1'b1;

   localparam logic [31:0] c_MIN_DIV = 32'd2;

   // Divisors below two cannot produce a distinct bit period, so they are clamped.
   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div < c_MIN_DIV) ? c_MIN_DIV : div;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with show-ahead head word read from the register array.
// Rev 1.0
`default_nettype none

module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_data,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_data,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == c_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Depth is a power of two, so natural pointer overflow gives the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-buffered UART transmitter with runtime baud, parity and stop-bit selection.
// Rev 1.0
`default_nettype none

module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16,
   parameter int DIV_RESET  = 868
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_BITS-1:0]              in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DIV_W-1:0]                  baud_div,
   input  logic                              parity_en,
   input  logic                              parity_odd,
   input  logic                              two_stop,
   output logic                              txd,
   output logic                              tx_busy,
   output logic                              frame_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   if ((DATA_BITS < 5) || (DATA_BITS > 9) || (FIFO_DEPTH < 2) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (DIV_RESET < 2)) begin : g_bad_params
      $error("uart_tx_fifo_param: illegal parameter combination");
   end

   localparam logic [3:0] c_LAST_DATA = 4'(DATA_BITS - 1);

   state_t               r_state;
   logic [DIV_W-1:0]     r_div;
   logic [DIV_W-1:0]     r_timer;
   logic [3:0]           r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_par_en;
   logic                 r_two_stop;
   logic                 r_txd;
   logic                 r_done;

   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_head;
   logic [DIV_W-1:0]     w_eff_div;
   logic                 w_bit_end;
   logic                 w_last_stop;
   logic                 w_frame_end;
   logic                 w_load;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_valid),
      .i_data  (in_data),
      .i_pop   (w_load),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign w_eff_div   = DIV_W'(eff_div(32'(baud_div)));
   assign w_bit_end   = (r_timer == (r_div - DIV_W'(1)));
   assign w_last_stop = (r_idx == {3'b000, r_two_stop});
   assign w_frame_end = (r_state == ST_STOP) && w_bit_end && w_last_stop;
   // The end of the last stop bit pops the next word directly, so frames abut.
   assign w_load      = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_txd      <= 1'b1;
         r_done     <= 1'b0;
         r_timer    <= '0;
         r_idx      <= '0;
         r_div      <= DIV_W'(2);
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_par_en   <= 1'b0;
         r_two_stop <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE) begin
            r_timer <= w_bit_end ? '0 : (r_timer + DIV_W'(1));
         end
         // txd reflects the state held during the previous clock.
         case (r_state)
            ST_IDLE: begin
               r_txd   <= 1'b1;
               r_timer <= '0;
               r_idx   <= '0;
            end
            ST_START: begin
               r_txd <= 1'b0;
               if (w_bit_end) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_txd <= r_shift[0];
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_idx == c_LAST_DATA) begin
                     r_idx   <= '0;
                     r_state <= r_par_en ? ST_PARITY : ST_STOP;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               r_txd <= r_par;
               if (w_bit_end) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               r_txd <= 1'b1;
               if (w_bit_end) begin
                  if (w_last_stop) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
         if (w_load) begin
            r_state    <= ST_START;
            r_timer    <= '0;
            r_idx      <= '0;
            r_shift    <= w_head;
            r_par      <= (^w_head) ^ (parity_odd == c_PAR_ODD);
            r_div      <= w_eff_div;
            r_par_en   <= parity_en;
            r_two_stop <= two_stop;
         end
      end
   end

   assign in_ready   = !w_full;
   assign txd        = r_txd;
   assign frame_done = r_done;
   assign tx_busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: vector table, corner sequences and random traffic against a waveform-queue model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo_param;

   localparam int DATA_BITS  = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [DATA_BITS-1:0] in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DIV_W-1:0]     baud_div = 16'd4;
   logic                 parity_en = 1'b0;
   logic                 parity_odd = 1'b0;
   logic                 two_stop = 1'b0;
   logic                 txd;
   logic                 tx_busy;
   logic                 frame_done;
   logic [2:0]           fifo_count;

   always #5 clk = ~clk;

   uart_tx_fifo_param #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W),
      .DIV_RESET  (868)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .two_stop   (two_stop),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .frame_done (frame_done),
      .fifo_count (fifo_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus a per-clock queue of {frame_done, txd} for frames already started.
   logic [1:0]           wave[$];
   logic [DATA_BITS-1:0] mq[$];
   logic                 m_txd = 1'b1;
   logic                 m_done = 1'b0;
   logic                 chk_en = 1'b0;

   task automatic add_frame(input logic [DATA_BITS-1:0] d, input int div, input bit pen, input bit podd, input bit two);
      int eff = (div < 2) ? 2 : div;
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ podd);
      bits.push_back(1'b1);
      if (two) bits.push_back(1'b1);
      foreach (bits[b]) begin
         for (int c = 0; c < eff; c++) wave.push_back({1'b0, bits[b]});
      end
      wave[wave.size()-1][1] = 1'b1;
   endtask

   always @(posedge clk) begin
      bit                   push_ok;
      logic [DATA_BITS-1:0] d;
      if (rst) begin
         mq.delete();
         wave.delete();
         m_txd  = 1'b1;
         m_done = 1'b0;
      end else begin
         push_ok = in_valid && (mq.size() < FIFO_DEPTH);
         if (wave.size() > 0) begin
            {m_done, m_txd} = wave.pop_front();
         end else begin
            m_done = 1'b0;
            m_txd  = 1'b1;
         end
         if (wave.size() == 0 && mq.size() > 0) begin
            d = mq.pop_front();
            add_frame(d, int'(baud_div), parity_en, parity_odd, two_stop);
         end
         if (push_ok) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("txd", int'(txd), int'(m_txd));
         check("frame_done", int'(frame_done), int'(m_done));
         check("tx_busy", int'(tx_busy), int'(wave.size() > 0));
         check("fifo_count", int'(fifo_count), mq.size());
         check("in_ready", int'(in_ready), int'(mq.size() < FIFO_DEPTH));
      end
   end

   logic cap_en = 1'b0;
   logic cap_t[$];
   logic cap_d[$];

   always @(negedge clk) begin
      if (cap_en) begin
         cap_t.push_back(txd);
         cap_d.push_back(frame_done);
      end
   end

   function automatic int cap_at(input int i);
      return (i >= 0 && i < cap_t.size()) ? int'(cap_t[i]) : -1;
   endfunction

   function automatic int first_low();
      foreach (cap_t[i]) if (cap_t[i] == 1'b0) return i;
      return -1;
   endfunction

   function automatic int done_pos(input int n);
      int k = 0;
      foreach (cap_d[i]) begin
         if (cap_d[i]) begin
            if (k == n) return i;
            k++;
         end
      end
      return -1;
   endfunction

   function automatic int done_total();
      int k = 0;
      foreach (cap_d[i]) if (cap_d[i]) k++;
      return k;
   endfunction

   function automatic int decode(input int base, input int eff);
      int v = 0;
      for (int b = 0; b < 8; b++) begin
         int s = cap_at(base + (b + 1) * eff + eff / 2);
         if (s < 0) return -1;
         v = v | (s << b);
      end
      return v;
   endfunction

   task automatic start_cap();
      cap_t.delete();
      cap_d.delete();
      cap_en = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_busy || fifo_count != 3'd0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(n < 5000), 1);
   endtask

   typedef struct {
      string      name;
      logic [7:0] data;
      int         div;
      bit         pen;
      bit         podd;
      bit         two;
      int         len;
      string      bits;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [7:0] d, input int dv, input bit pe,
                               input bit po, input bit tw, input int ln, input string b);
      vec_t v;
      v.name = n; v.data = d; v.div = dv; v.pen = pe; v.podd = po; v.two = tw; v.len = ln; v.bits = b;
      return v;
   endfunction

   vec_t vecs[7];

   task automatic run_vec(input vec_t v);
      int   lat = 0;
      int   eff = (v.div < 2) ? 2 : v.div;
      int   got;
      int   cnt = 0;
      int   pos = -1;
      int   exp_b;
      logic s[$];
      logic dn[$];
      wait_idle();
      @(negedge clk);
      baud_div   = 16'(v.div);
      parity_en  = v.pen;
      parity_odd = v.podd;
      two_stop   = v.two;
      in_data    = v.data;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      while (txd && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, lat, 2);
      for (int j = 0; j < v.len + 2; j++) begin
         if (j > 0) @(negedge clk);
         s.push_back(txd);
         dn.push_back(frame_done);
      end
      for (int b = 0; b < v.bits.len(); b++) begin
         exp_b = (v.bits[b] == 8'h31) ? 1 : 0;
         got = exp_b;
         for (int c = 0; c < eff; c++) if (int'(s[b * eff + c]) != exp_b) got = int'(s[b * eff + c]);
         check($sformatf("%s bit%0d", v.name, b), got, exp_b);
      end
      foreach (dn[j]) begin
         if (dn[j]) begin
            cnt++;
            if (pos < 0) pos = j;
         end
      end
      check({v.name, " done_count"}, cnt, 1);
      check({v.name, " frame_len"}, pos + 1, v.len);
      check({v.name, " idle_after"}, int'(s[v.len]), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      int   n;
      bit   acc;
      bit   full_seen;

      vecs[0] = mk("8N1_A5",   8'hA5, 4, 1'b0, 1'b0, 1'b0, 40, "0101001011");
      vecs[1] = mk("8E1_07",   8'h07, 4, 1'b1, 1'b0, 1'b0, 44, "01110000011");
      vecs[2] = mk("8O1_07",   8'h07, 4, 1'b1, 1'b1, 1'b0, 44, "01110000001");
      vecs[3] = mk("8N2_00",   8'h00, 2, 1'b0, 1'b0, 1'b1, 22, "00000000011");
      vecs[4] = mk("8N2_FF",   8'hFF, 2, 1'b0, 1'b0, 1'b1, 22, "01111111111");
      vecs[5] = mk("div0_3C",  8'h3C, 0, 1'b0, 1'b0, 1'b0, 20, "0001111001");
      vecs[6] = mk("div1_8O2", 8'h5A, 1, 1'b1, 1'b1, 1'b1, 24, "001011010111");

      repeat (3) @(negedge clk);
      check("reset txd", int'(txd), 1);
      check("reset tx_busy", int'(tx_busy), 0);
      check("reset frame_done", int'(frame_done), 0);
      check("reset fifo_count", int'(fifo_count), 0);
      check("reset in_ready", int'(in_ready), 1);
      rst    = 1'b0;
      chk_en = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back 8N2 frames at divisor 2.
      wait_idle();
      @(negedge clk);
      baud_div = 16'd2; parity_en = 1'b0; two_stop = 1'b1;
      start_cap();
      in_data = 8'h00; in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      cap_en = 1'b0;
      t0 = first_low();
      check("b2b first_done", done_pos(0) - t0, 21);
      check("b2b second_done", done_pos(1) - t0, 43);
      check("b2b last_stop_high", cap_at(t0 + 21), 1);
      check("b2b second_start", cap_at(t0 + 22), 0);
      check("b2b byte1", decode(t0 + 22, 2), 255);

      // Six bytes with in_valid held, FIFO fills up.
      wait_idle();
      @(negedge clk);
      baud_div = 16'd3; two_stop = 1'b0;
      start_cap();
      full_seen = 1'b0;
      in_data = 8'd1; in_valid = 1'b1;
      for (n = 0; n < 500 && in_valid; n++) begin
         acc = in_ready;
         @(negedge clk);
         if (fifo_count == 3'd4) begin
            full_seen = 1'b1;
            check("six ready_when_full", int'(in_ready), 0);
         end
         if (acc) begin
            if (in_data == 8'd6) in_valid = 1'b0;
            else in_data = in_data + 8'd1;
         end
      end
      check("six full_seen", int'(full_seen), 1);
      wait_idle();
      repeat (2) @(negedge clk);
      cap_en = 1'b0;
      t0 = first_low();
      for (int f = 0; f < 6; f++) begin
         check($sformatf("six start%0d", f), cap_at(t0 + f * 30 + 1), 0);
         check($sformatf("six byte%0d", f), decode(t0 + f * 30, 3), f + 1);
      end
      check("six done_total", done_total(), 6);

      // Divisor change mid-frame only affects the following frame.
      wait_idle();
      @(negedge clk);
      baud_div = 16'd4;
      start_cap();
      in_data = 8'h55; in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'h33;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      baud_div = 16'd8;
      wait_idle();
      repeat (2) @(negedge clk);
      cap_en = 1'b0;
      t0 = first_low();
      check("baud first_done", done_pos(0) - t0, 39);
      check("baud second_done", done_pos(1) - t0, 119);
      check("baud byte0", decode(t0, 4), 8'h55);
      check("baud byte1", decode(t0 + 40, 8), 8'h33);

      // Reset mid-DATA with two bytes still queued.
      wait_idle();
      @(negedge clk);
      baud_div = 16'd4;
      in_data = 8'h11; in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'h22;
      @(negedge clk);
      in_data = 8'h33;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (txd && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst queued", int'(fifo_count), 2);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst txd", int'(txd), 1);
      check("rst fifo_count", int'(fifo_count), 0);
      check("rst tx_busy", int'(tx_busy), 0);
      start_cap();
      repeat (60) @(negedge clk);
      cap_en = 1'b0;
      check("rst no_done", done_total(), 0);
      run_vec(vecs[0]);

      // Random traffic with mid-stream configuration changes.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = 8'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            baud_div   = 16'($urandom_range(0, 5));
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            two_stop   = 1'($urandom);
         end
         rst = ($urandom_range(0, 1499) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
